// File: rtl/debounce_timer_arbiter.sv
// rtl/debounce_timer_arbiter.sv - multi-channel debouncer sharing one delay timer round-robin
module debounce_timer_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int DELAY   = 100,
  parameter int CNT_W   = 8,
  parameter int PTR_W   = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] sync_in,
  output logic [NUM_CH-1:0] deb_out,
  output logic [NUM_CH-1:0] change_pulse,
  output logic              busy,
  output logic [PTR_W-1:0]  grant_ch
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  count;
  logic [NUM_CH-1:0] req;
  logic              pick_valid;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  scan_idx;

  // Channel index plus one, wrapping at NUM_CH rather than at 2^PTR_W.
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
    if (int'(i) >= NUM_CH - 1) return '0;
    else return i + PTR_W'(1);
  endfunction

  // A channel wants the timer whenever its input disagrees with its debounced output.
  assign req = sync_in ^ deb_out;

  // Round-robin pick: first requester scanning upward from rr_ptr.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = rr_ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!pick_valid && req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
  end

  // Timer ownership FSM: grant in IDLE, then abort, complete or count in RUN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      deb_out      <= {NUM_CH{RST_VAL}};
      change_pulse <= '0;
      busy         <= 1'b0;
      grant_ch     <= '0;
      rr_ptr       <= '0;
      count        <= '0;
      state        <= ST_IDLE;
    end else begin
      change_pulse <= '0;
      if (state == ST_IDLE) begin
        if (pick_valid) begin
          grant_ch <= pick_idx;
          count    <= '0;
          busy     <= 1'b1;
          state    <= ST_RUN;
        end
      end else begin
        if (!req[grant_ch]) begin
          // Input bounced back before the delay elapsed; drop the attempt.
          state  <= ST_IDLE;
          busy   <= 1'b0;
          rr_ptr <= next_idx(grant_ch);
        end else if (count == CNT_W'(DELAY - 1)) begin
          deb_out[grant_ch]      <= sync_in[grant_ch];
          change_pulse[grant_ch] <= 1'b1;
          state                  <= ST_IDLE;
          busy                   <= 1'b0;
          rr_ptr                 <= next_idx(grant_ch);
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// tb/tb_debounce_timer_arbiter.sv - randomized and directed bench for debounce_timer_arbiter
module tb_debounce_timer_arbiter;

  localparam int NCH = 4;
  localparam int DLY = 4;

  logic           CLK;
  logic           RST;
  logic [NCH-1:0] sync_in;
  logic [NCH-1:0] deb_out;
  logic [NCH-1:0] change_pulse;
  logic           busy;
  logic [1:0]     grant_ch;

  int n_checks;
  int n_fail;

  debounce_timer_arbiter #(
    .NUM_CH (NCH),
    .DELAY  (DLY),
    .CNT_W  (8),
    .PTR_W  (2),
    .RST_VAL(1'b0)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .sync_in     (sync_in),
    .deb_out     (deb_out),
    .change_pulse(change_pulse),
    .busy        (busy),
    .grant_ch    (grant_ch)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: owner = -1 while the timer is free, elapsed = edges spent in RUN.
  int             m_owner;
  int             m_elapsed;
  int             m_ptr;
  int             m_grant;
  logic [NCH-1:0] m_deb;
  logic [NCH-1:0] m_pulse;
  bit             m_valid;

  initial m_valid = 1'b0;

  // Reference model advances on every rising edge from the pre-edge inputs.
  always @(posedge CLK) begin : model_blk
    int c;
    if (RST) begin
      m_deb   = '0;
      m_pulse = '0;
      m_owner = -1;
      m_grant = 0;
      m_ptr   = 0;
      m_elapsed = 0;
      m_valid = 1'b1;
    end else begin
      m_pulse = '0;
      if (m_owner < 0) begin
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (sync_in[c] != m_deb[c]) begin
            m_owner   = c;
            m_grant   = c;
            m_elapsed = 0;
            break;
          end
        end
      end else if (sync_in[m_owner] == m_deb[m_owner]) begin
        m_ptr   = (m_owner + 1) % NCH;
        m_owner = -1;
      end else if (m_elapsed == DLY - 1) begin
        m_deb[m_owner]   = sync_in[m_owner];
        m_pulse[m_owner] = 1'b1;
        m_ptr   = (m_owner + 1) % NCH;
        m_owner = -1;
      end else begin
        m_elapsed++;
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the reference, away from the rising edge.
  always @(negedge CLK) begin
    if (m_valid) begin
      check("deb_out", 32'(deb_out), 32'(m_deb));
      check("change_pulse", 32'(change_pulse), 32'(m_pulse));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("grant_ch", 32'(grant_ch), 32'(m_grant));
      check("pulse_onehot", 32'($countones(change_pulse) <= 1), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset(input logic [NCH-1:0] s);
    RST     = 1'b1;
    sync_in = s;
    step(2);
    RST = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    sync_in  = 4'b1111;

    // Reset with all inputs high
    step(2);
    check("rst_deb", 32'(deb_out), 32'h0);
    check("rst_pulse", 32'(change_pulse), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_grant", 32'(grant_ch), 32'h0);
    RST = 1'b0;
    step(1);
    check("first_grant_ch", 32'(grant_ch), 32'h0);
    check("first_grant_busy", 32'(busy), 32'h1);
    step(25);
    check("all_high_deb", 32'(deb_out), 32'hf);

    // Single clean press on channel 2
    do_reset(4'b0000);
    step(2);
    sync_in = 4'b0100;
    step(1);
    check("press_grant", 32'(grant_ch), 32'h2);
    check("press_busy", 32'(busy), 32'h1);
    step(3);
    check("press_not_yet", 32'(deb_out), 32'h0);
    step(1);
    check("press_deb", 32'(deb_out), 32'h4);
    check("press_pulse", 32'(change_pulse), 32'h4);
    check("press_idle", 32'(busy), 32'h0);
    check("model_press_deb", 32'(m_deb), 32'h4);
    step(1);
    check("press_pulse_gone", 32'(change_pulse), 32'h0);

    // Bounce abort on channel 1, then 0 and 3 request together
    sync_in = 4'b0110;
    step(1);
    check("bounce_grant", 32'(grant_ch), 32'h1);
    step(1);
    sync_in = 4'b0100;
    step(1);
    check("bounce_busy", 32'(busy), 32'h0);
    check("bounce_deb", 32'(deb_out), 32'h4);
    check("bounce_pulse", 32'(change_pulse), 32'h0);
    sync_in = 4'b1101;
    step(1);
    check("after_abort_grant", 32'(grant_ch), 32'h3);
    step(12);
    check("after_abort_deb", 32'(deb_out), 32'hd);

    // Contention 0 -> 1011
    do_reset(4'b0000);
    sync_in = 4'b1011;
    step(1);
    check("cont_g0", 32'(grant_ch), 32'h0);
    step(5);
    check("cont_g1", 32'(grant_ch), 32'h1);
    check("cont_deb1", 32'(deb_out), 32'h1);
    step(5);
    check("cont_g3", 32'(grant_ch), 32'h3);
    check("cont_deb2", 32'(deb_out), 32'h3);
    step(4);
    check("cont_deb3", 32'(deb_out), 32'hb);
    check("cont_pulse3", 32'(change_pulse), 32'h8);
    check("model_cont_deb", 32'(m_deb), 32'hb);

    // Waiting channel 3 toggles while channel 0 owns the timer
    do_reset(4'b0000);
    sync_in = 4'b0001;
    step(1);
    for (int i = 0; i < 3; i++) begin
      sync_in = (i % 2 == 0) ? 4'b1001 : 4'b0001;
      step(1);
    end
    sync_in = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("wait_deb3", 32'(deb_out[3]), 32'h0);
    end
    check("wait_deb", 32'(deb_out), 32'h1);
    check("wait_grant", 32'(grant_ch), 32'h0);

    // Reset in the middle of a run on channel 1
    do_reset(4'b0000);
    sync_in = 4'b0010;
    step(3);
    RST = 1'b1;
    step(1);
    check("midrst_deb", 32'(deb_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_grant", 32'(grant_ch), 32'h0);
    RST = 1'b0;
    step(1);
    check("midrst_regrant", 32'(grant_ch), 32'h1);
    check("midrst_rebusy", 32'(busy), 32'h1);
    step(4);
    check("midrst_deb_done", 32'(deb_out), 32'h2);
    check("midrst_pulse", 32'(change_pulse), 32'h2);

    // Randomized traffic with varying toggle rates and occasional resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int rate;
      rate = ((cyc / 500) % 2 == 1) ? 12 : 3;
      RST = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, rate) == 0)
        sync_in = sync_in ^ (4'b0001 << $urandom_range(0, 3));
      step(1);
    end
    RST = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
